// File: rtl/reg_trace_mon.sv
// ---------------------------------------------------------------------------
// reg_trace_mon
//
// Register-file trace monitor. Snoops the register-file write port, mirrors a
// window of CH_N consecutive architectural registers starting at WATCH_BASE
// into shadow copies, and queues a time-stamped record of each qualifying
// write into a show-ahead FIFO drained over a valid/ready handshake.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-low
//   en           logging enable (shadows update regardless)
//   clr_ovf      clears ovf / ovf_cnt (wins over a same-cycle drop)
//   wr_en        register-file write strobe
//   wr_addr      register-file write address
//   wr_data      register-file write data
//   shadow       mirrored values, channel k at [k*DATA_W +: DATA_W]
//   trace_valid  FIFO non-empty
//   trace_ready  consumer accepts head entry
//   trace_addr   register index of head entry (0 when empty)
//   trace_data   written value of head entry (0 when empty)
//   trace_cyc    time stamp of head entry (0 when empty)
//   ovf          sticky: at least one entry dropped
//   ovf_cnt      dropped-entry count, saturating at 255
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module reg_trace_mon #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int WATCH_BASE = 27,
  parameter int CH_N       = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int CYC_W      = 16,
  parameter int MODE       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr_ovf,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [CH_N*DATA_W-1:0]   shadow,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [ADDR_W-1:0]        trace_addr,
  output logic [DATA_W-1:0]        trace_data,
  output logic [CYC_W-1:0]         trace_cyc,
  output logic                     ovf,
  output logic [7:0]               ovf_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CYC_W-1:0]  cyc;
  } entry_t;

  logic [CYC_W-1:0]  r_cyc;
  logic [DATA_W-1:0] r_shadow [CH_N];
  entry_t            r_mem    [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic [7:0]        r_ovf_cnt;

  logic [CH_N-1:0]   w_sel;
  logic [DATA_W-1:0] w_cur;
  logic              w_hit;
  logic              w_changed;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_wr;
  logic              w_drop;
  entry_t            w_entry;
  entry_t            w_head;

  // -------------------------------------------------------------------------
  // Channel decode: one-hot select of the watched register being written,
  // plus the shadow value it holds before this write (for change detection).
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_sel = '0;
    w_cur = '0;
    for (int k = 0; k < CH_N; k++) begin
      if (wr_en && (wr_addr != '0) &&
          ({1'b0, wr_addr} == (ADDR_W+1)'(WATCH_BASE + k))) begin
        w_sel[k] = 1'b1;
        w_cur    = r_shadow[k];
      end
    end
  end

  assign w_hit     = |w_sel;
  assign w_changed = (w_cur != wr_data);
  assign w_push    = w_hit && en && ((MODE == 0) || w_changed);

  // FIFO control: a push into a full FIFO still lands if the head leaves on
  // the same edge; otherwise it is dropped and counted.
  assign trace_valid = (r_count != '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = trace_valid && trace_ready;
  assign w_wr        = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;

  assign w_entry = '{addr: wr_addr, data: wr_data, cyc: r_cyc};
  assign w_head  = r_mem[r_rptr];

  // Head is forced to zero when empty so stale storage never shows.
  assign trace_addr = trace_valid ? w_head.addr : '0;
  assign trace_data = trace_valid ? w_head.data : '0;
  assign trace_cyc  = trace_valid ? w_head.cyc  : '0;
  assign ovf        = r_ovf;
  assign ovf_cnt    = r_ovf_cnt;

  always_comb begin
    shadow = '0;
    for (int k = 0; k < CH_N; k++) begin
      shadow[k*DATA_W +: DATA_W] = r_shadow[k];
    end
  end

  // -------------------------------------------------------------------------
  // Time stamp and shadow registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      r_cyc <= '0;
      for (int k = 0; k < CH_N; k++) r_shadow[k] <= '0;
    end else begin
      r_cyc <= r_cyc + 1'b1;
      for (int k = 0; k < CH_N; k++) begin
        if (w_sel[k]) r_shadow[k] <= wr_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers / occupancy
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by r_count and
  // the outputs are masked while empty, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_entry;
  end

  // -------------------------------------------------------------------------
  // Overflow tracking: clear has priority over a same-cycle drop.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (clr_ovf) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_reg_trace_mon.sv
// ---------------------------------------------------------------------------
// tb_reg_trace_mon
//
// Drives two reg_trace_mon instances (MODE 0 and MODE 1) from shared inputs.
// Directed vectors, hand-written corner sequences and a randomized phase are
// all checked against a queue-based reference model of the trace behaviour.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_reg_trace_mon;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int BASE  = 27;
  localparam int CHN   = 3;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              clr_ovf;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              trace_ready;

  logic [CHN*DW-1:0] sh0, sh1;
  logic              tv0, tv1;
  logic [AW-1:0]     ta0, ta1;
  logic [DW-1:0]     td0, td1;
  logic [CW-1:0]     tc0, tc1;
  logic              ov0, ov1;
  logic [7:0]        oc0, oc1;

  always #5 clk = ~clk;

  reg_trace_mon #(.DATA_W(DW), .ADDR_W(AW), .WATCH_BASE(BASE), .CH_N(CHN),
                  .FIFO_DEPTH(DEPTH), .CYC_W(CW), .MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .clr_ovf(clr_ovf), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .shadow(sh0), .trace_valid(tv0),
    .trace_ready(trace_ready), .trace_addr(ta0), .trace_data(td0),
    .trace_cyc(tc0), .ovf(ov0), .ovf_cnt(oc0));

  reg_trace_mon #(.DATA_W(DW), .ADDR_W(AW), .WATCH_BASE(BASE), .CH_N(CHN),
                  .FIFO_DEPTH(DEPTH), .CYC_W(CW), .MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .clr_ovf(clr_ovf), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .shadow(sh1), .trace_valid(tv1),
    .trace_ready(trace_ready), .trace_addr(ta1), .trace_data(td1),
    .trace_cyc(tc1), .ovf(ov1), .ovf_cnt(oc1));

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [CW-1:0] cyc;
  } ent_t;

  ent_t        mq [2][$];
  logic [DW-1:0] m_sh [2][CHN];
  logic        m_ovf [2];
  int          m_cnt [2];
  int          m_cyc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies the current inputs to the model as the next clock edge would.
  task automatic model_step();
    bit   in_win, push, pop, full;
    int   ch;
    ent_t e;
    for (int m = 0; m < 2; m++) begin
      if (!rst) begin
        mq[m].delete();
        for (int c = 0; c < CHN; c++) m_sh[m][c] = '0;
        m_ovf[m] = 1'b0;
        m_cnt[m] = 0;
      end else begin
        in_win = wr_en && (int'(wr_addr) != 0) && (int'(wr_addr) >= BASE) &&
                 (int'(wr_addr) < BASE + CHN);
        ch   = int'(wr_addr) - BASE;
        push = in_win && en && ((m == 0) || (m_sh[m][ch] != wr_data));
        full = (mq[m].size() == DEPTH);
        pop  = (mq[m].size() > 0) && trace_ready;
        if (pop) void'(mq[m].pop_front());
        if (push && (!full || pop)) begin
          e.addr = wr_addr;
          e.data = wr_data;
          e.cyc  = CW'(m_cyc);
          mq[m].push_back(e);
        end
        if (clr_ovf) begin
          m_ovf[m] = 1'b0;
          m_cnt[m] = 0;
        end else if (push && full && !pop) begin
          m_ovf[m] = 1'b1;
          if (m_cnt[m] < 255) m_cnt[m]++;
        end
        if (in_win) m_sh[m][ch] = wr_data;
      end
    end
    m_cyc = rst ? ((m_cyc + 1) % (1 << CW)) : 0;
  endtask

  task automatic cmp_inst(input int m, input logic v, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [CW-1:0] c,
                          input logic ov, input logic [7:0] oc,
                          input logic [CHN*DW-1:0] sh);
    ent_t h;
    logic ev;
    ev = (mq[m].size() > 0);
    if (ev) h = mq[m][0];
    else begin
      h.addr = '0; h.data = '0; h.cyc = '0;
    end
    check($sformatf("m%0d trace_valid", m), 64'(v),  64'(ev));
    check($sformatf("m%0d trace_addr", m),  64'(a),  64'(h.addr));
    check($sformatf("m%0d trace_data", m),  64'(d),  64'(h.data));
    check($sformatf("m%0d trace_cyc", m),   64'(c),  64'(h.cyc));
    check($sformatf("m%0d ovf", m),         64'(ov), 64'(m_ovf[m]));
    check($sformatf("m%0d ovf_cnt", m),     64'(oc), 64'(m_cnt[m]));
    for (int k = 0; k < CHN; k++)
      check($sformatf("m%0d shadow[%0d]", m, k), 64'(sh[k*DW +: DW]), 64'(m_sh[m][k]));
  endtask

  // One clock: model update, edge, then compare both instances #1 later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cmp_inst(0, tv0, ta0, td0, tc0, ov0, oc0, sh0);
    cmp_inst(1, tv1, ta1, td1, tc1, ov1, oc1, sh1);
  endtask

  task automatic set_in(input logic i_rst, input logic i_en, input logic i_wr,
                        input int addr, input int data, input logic i_rdy,
                        input logic i_clr);
    rst         = i_rst;
    en          = i_en;
    wr_en       = i_wr;
    wr_addr     = AW'(addr);
    wr_data     = DW'(data);
    trace_ready = i_rdy;
    clr_ovf     = i_clr;
  endtask

  task automatic write(input int addr, input int data, input logic rdy);
    set_in(1'b1, 1'b1, 1'b1, addr, data, rdy, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst, en, wr_en, ready, clr;
    int            addr;
    int            data;
    logic          exp_valid;
    int            exp_addr;
    int            exp_data;
    int            exp_cyc;
    int            e27, e28, e29;
  } vec_t;

  vec_t vt [8];

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic [DW-1:0] last;
    int   thr;

    m_cyc = 0;
    for (int m = 0; m < 2; m++) begin
      m_ovf[m] = 1'b0;
      m_cnt[m] = 0;
      for (int c = 0; c < CHN; c++) m_sh[m][c] = '0;
    end
    set_in(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    //         rst en wr rdy clr addr data  v  addr data cyc  27 28 29
    vt[0] = '{1'b0,1'b1,1'b0,1'b1,1'b0,  0,  0, 1'b0,  0,  0, 0,  0, 0,  0};
    vt[1] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 27,  5, 1'b1, 27,  5, 0,  5, 0,  0};
    vt[2] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 28,  7, 1'b1, 28,  7, 1,  5, 7,  0};
    vt[3] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 29, 12, 1'b1, 29, 12, 2,  5, 7, 12};
    vt[4] = '{1'b1,1'b1,1'b1,1'b1,1'b0,  0,  9, 1'b0,  0,  0, 0,  5, 7, 12};
    vt[5] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 26,  1, 1'b0,  0,  0, 0,  5, 7, 12};
    vt[6] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 30,  1, 1'b0,  0,  0, 0,  5, 7, 12};
    vt[7] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 27, 99, 1'b0,  0,  0, 0,  5, 7, 12};

    for (int i = 0; i < 8; i++) begin
      set_in(vt[i].rst, vt[i].en, vt[i].wr_en, vt[i].addr, vt[i].data,
             vt[i].ready, vt[i].clr);
      tick();
      check($sformatf("vec%0d valid", i), 64'(tv0), 64'(vt[i].exp_valid));
      check($sformatf("vec%0d addr", i),  64'(ta0), 64'(vt[i].exp_addr));
      check($sformatf("vec%0d data", i),  64'(td0), 64'(vt[i].exp_data));
      check($sformatf("vec%0d cyc", i),   64'(tc0), 64'(vt[i].exp_cyc));
      check($sformatf("vec%0d x27", i),   64'(sh0[0*DW +: DW]), 64'(vt[i].e27));
      check($sformatf("vec%0d x28", i),   64'(sh0[1*DW +: DW]), 64'(vt[i].e28));
      check($sformatf("vec%0d x29", i),   64'(sh0[2*DW +: DW]), 64'(vt[i].e29));
    end

    // --- MODE 1 change filter: 7, 7, 8 logs two entries ---
    do_reset();
    write(28, 7, 1'b0);
    write(28, 7, 1'b0);
    write(28, 8, 1'b0);
    set_in(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    check("mode1 first head", 64'(td1), 64'd7);
    trace_ready = 1'b1;
    tick();
    check("mode1 second head", 64'(td1), 64'd8);
    check("mode1 second valid", 64'(tv1), 64'd1);
    tick();
    check("mode1 drained", 64'(tv1), 64'd0);
    tick();

    // --- overflow: 10 writes with ready low, depth 8 ---
    do_reset();
    for (int i = 1; i <= 10; i++) write(27, i, 1'b0);
    set_in(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    check("ovf set m0", 64'(ov0), 64'd1);
    check("ovf_cnt m0", 64'(oc0), 64'd2);
    check("ovf_cnt m1", 64'(oc1), 64'd2);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain order %0d", i), 64'(td0), 64'(i + 1));
      trace_ready = 1'b1;
      tick();
    end
    check("drain empty", 64'(tv0), 64'd0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr ovf", 64'(ov0), 64'd0);
    check("clr ovf_cnt", 64'(oc0), 64'd0);

    // --- full FIFO with simultaneous push and pop ---
    do_reset();
    for (int i = 0; i < 8; i++) write(27, 21 + i, 1'b0);
    write(27, 100, 1'b1);
    check("full push+pop no ovf", 64'(ov0), 64'd0);
    check("full push+pop ovf_cnt", 64'(oc0), 64'd0);
    set_in(1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    n = 0;
    last = '0;
    for (int g = 0; g < 20 && tv0; g++) begin
      last = td0;
      n++;
      tick();
    end
    check("full push+pop occupancy", 64'(n), 64'd8);
    check("full push+pop last", 64'(last), 64'd100);

    // --- drop and clr_ovf in the same cycle: clear wins ---
    for (int i = 0; i < 8; i++) write(28, 40 + i, 1'b0);
    set_in(1'b1, 1'b1, 1'b1, 28, 77, 1'b0, 1'b1);
    tick();
    check("clr beats drop ovf", 64'(ov0), 64'd0);
    check("clr beats drop cnt", 64'(oc0), 64'd0);
    write(28, 78, 1'b0);
    check("drop after clr cnt", 64'(oc0), 64'd1);

    // --- reset mid-operation, then en=0 writes ---
    do_reset();
    write(27, 1, 1'b0);
    write(28, 2, 1'b0);
    write(29, 3, 1'b0);
    do_reset();
    check("mid reset valid", 64'(tv0), 64'd0);
    check("mid reset shadow", 64'(sh0 == '0), 64'd1);
    set_in(1'b1, 1'b0, 1'b1, 28, 55, 1'b0, 1'b0);
    tick();
    check("en0 no entry", 64'(tv0), 64'd0);
    check("en0 shadow x28", 64'(sh0[1*DW +: DW]), 64'd55);
    write(27, 4, 1'b0);
    check("cyc restart stamp", 64'(tc0), 64'd1);

    // --- randomized phase ---
    thr = 50;
    for (int i = 0; i < 2400; i++) begin
      if (i % 200 == 0) thr = (i / 200) % 3 == 0 ? 10 : ((i / 200) % 3 == 1 ? 90 : 50);
      rst         = ($urandom_range(0, 99) != 0);
      en          = ($urandom_range(0, 9) != 0);
      wr_en       = ($urandom_range(0, 9) < 7);
      wr_addr     = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(26, 30))
                                                : AW'($urandom_range(0, 31));
      wr_data     = DW'($urandom_range(0, 3));
      trace_ready = ($urandom_range(0, 99) < thr);
      clr_ovf     = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
